// File: rtl/avr_prefetch.sv
// avr_prefetch: instruction prefetch queue between the synchronous program ROM
// and avr_fetch. Streams sequential words ahead of the fetch address and flushes
// and restarts on any non-sequential request.
// Optional feature: define AVR_PF_BYPASS_EN to forward a ROM response straight to
// fetch when the queue is empty, giving one-cycle redirect-to-valid latency.
module avr_prefetch #(
   parameter int DEPTH  = 4,   // power of two, 2..16
   parameter int ADDR_W = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [ADDR_W-1:0] fetch_addr,
   input  logic              fetch_take,
   output logic [15:0]       fetch_data,
   output logic              fetch_valid,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int OCC_W = CNT_W + 1;

   logic [ADDR_W-1:0] head_addr_q, head_addr_d;
   logic [ADDR_W-1:0] issue_addr_q, issue_addr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic              inflight_q, inflight_d;
   logic [15:0]       mem_q [DEPTH];

   logic              redirect;
   logic              queue_nonempty;
   logic              bypass;
   logic              hit;
   logic              take;
   logic              push;
   logic              pop;
   logic [PTR_W-1:0]  wr_ptr;
   logic [OCC_W-1:0]  occupancy;

   // Hit/miss/redirect decode, fetch-side outputs and ROM request.
   // The ROM answers one cycle after rom_en, so a response that overlaps a
   // redirect is the only stale word that can exist; gating push with redirect
   // drops it in that same cycle, and the read issued on the redirect is already
   // for the new stream, so no kill flag has to survive the edge.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
      fetch_data     = '0;
      fetch_valid    = 1'b0;
      rom_en         = 1'b0;
      rom_addr       = '0;
      redirect       = (fetch_addr != head_addr_q);
      queue_nonempty = (count_q != '0);
`ifdef AVR_PF_BYPASS_EN
      bypass         = !queue_nonempty && inflight_q && !redirect;
`else
      bypass         = 1'b0;
`endif
      hit            = !redirect && (queue_nonempty || bypass);
      take           = fetch_take && hit;
      // An empty-queue take consumes the bypassed word, so it is neither pushed nor popped.
      pop            = take && queue_nonempty;
      push           = inflight_q && !redirect && !(take && !queue_nonempty);
      wr_ptr         = rd_ptr_q + PTR_W'(count_q);
      occupancy      = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(take);

      if (hit) begin
         fetch_valid = 1'b1;
         fetch_data  = queue_nonempty ? mem_q[rd_ptr_q] : rom_data;
      end

      if (!RST) begin
         if (redirect) begin
            rom_en   = 1'b1;
            rom_addr = fetch_addr;
         end else begin
            rom_en   = (occupancy < OCC_W'(DEPTH));
            rom_addr = issue_addr_q;
         end
      end
   end

   // Next-state for queue bookkeeping and stream addresses.
   always_comb begin
      head_addr_d  = head_addr_q;
      issue_addr_d = issue_addr_q;
      count_d      = count_q;
      rd_ptr_d     = rd_ptr_q;
      inflight_d   = rom_en;

      if (redirect) begin
         head_addr_d  = fetch_addr;
         issue_addr_d = fetch_addr + ADDR_W'(1);
         count_d      = '0;
      end else begin
         if (rom_en) begin
            issue_addr_d = issue_addr_q + ADDR_W'(1);
         end
         if (take) begin
            head_addr_d = head_addr_q + ADDR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // State register with synchronous reset; reset also discards any in-flight response.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (RST) begin
         head_addr_q  <= '0;
         issue_addr_q <= '0;
         count_q      <= '0;
         rd_ptr_q     <= '0;
         inflight_q   <= 1'b0;
      end else begin
         head_addr_q  <= head_addr_d;
         issue_addr_q <= issue_addr_d;
         count_q      <= count_d;
         rd_ptr_q     <= rd_ptr_d;
         inflight_q   <= inflight_d;
      end
   end

   // Queue storage: write the ROM response at the tail.
   always_ff @(posedge CLK) begin
      // NOTE: storage is not reset; count_q alone decides which entries hold data.
      if (push) begin
         mem_q[wr_ptr] <= rom_data;
      end
   end

endmodule

// File: tb/tb_avr_prefetch.sv
// tb_avr_prefetch: self-checking bench for avr_prefetch. The ROM model returns
// 16'h1000 + address one cycle after rom_en; a scoreboard checks every valid
// word against the ROM contents at fetch_addr.
module tb_avr_prefetch;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 16;
`ifdef AVR_PF_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic [ADDR_W-1:0] fetch_addr = '0;
   logic              fetch_take = 1'b0;
   logic [15:0]       fetch_data;
   logic              fetch_valid;
   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [15:0]       rom_data = 16'hDEAD;

   int tests_run    = 0;
   int tests_failed = 0;

   logic              rom_en_s   = 1'b0;
   logic [ADDR_W-1:0] rom_addr_s = '0;

   avr_prefetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .fetch_addr (fetch_addr),
      .fetch_take (fetch_take),
      .fetch_data (fetch_data),
      .fetch_valid(fetch_valid),
      .rom_en     (rom_en),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   function automatic logic [15:0] rom_word(input logic [ADDR_W-1:0] a);
      return 16'h1000 + a;
   endfunction

   // Let combinational outputs settle, then run the scoreboard and the
   // never-more-than-DEPTH-words-ahead bound.
   task automatic eval();
      logic [ADDR_W-1:0] ahead;
      #1;
      if (fetch_valid === 1'b1) begin
         tests_run++;
         if (fetch_data !== rom_word(fetch_addr)) begin
            tests_failed++;
            $display("FAIL scoreboard addr=%h: got %h, want %h", fetch_addr, fetch_data, rom_word(fetch_addr));
         end
      end
      if (rom_en === 1'b1) begin
         ahead = rom_addr - fetch_addr;
         tests_run++;
         if (ahead >= ADDR_W'(DEPTH) + ADDR_W'(fetch_take & fetch_valid)) begin
            tests_failed++;
            $display("FAIL queue_overflow: issue %h is %0d words ahead of head %h", rom_addr, ahead, fetch_addr);
         end
      end
   endtask

   // Advance one clock; the ROM model answers the request seen before the edge.
   task automatic clk_edge();
      rom_en_s   = rom_en;
      rom_addr_s = rom_addr;
      @(posedge CLK);
      #1;
      rom_data = rom_en_s ? rom_word(rom_addr_s) : 16'hDEAD;
   endtask

   task automatic check_reset_outputs(input string tag);
      tests_run++;
      if (fetch_valid !== 1'b0 || fetch_data !== 16'h0000 || rom_en !== 1'b0 || rom_addr !== '0) begin
         tests_failed++;
         $display("FAIL %s: got valid=%b data=%h en=%b addr=%h, want 0 0000 0 0000",
                  tag, fetch_valid, fetch_data, rom_en, rom_addr);
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      fetch_addr = '0;
      fetch_take = 1'b0;
      clk_edge();
      clk_edge();
      eval();
      check_reset_outputs("reset_values");
   endtask

   // Release reset with fetch_addr=0 and take every valid word.
   task automatic test_stream(input int n_cycles);
      logic [ADDR_W-1:0] a;
      int words;
      a = '0;
      words = 0;
      RST = 1'b0;
      fetch_take = 1'b1;
      for (int c = 0; c < n_cycles; c++) begin
         fetch_addr = a;
         eval();
         if (c == 0) begin
            tests_run++;
            if (rom_en !== 1'b1 || rom_addr !== '0) begin
               tests_failed++;
               $display("FAIL stream_first_issue: got en=%b addr=%h, want 1 0000", rom_en, rom_addr);
            end
         end
         tests_run++;
         if (fetch_valid !== (c >= LAT)) begin
            tests_failed++;
            $display("FAIL stream_valid cycle %0d: got %b, want %b", c, fetch_valid, (c >= LAT));
         end
         if (fetch_valid === 1'b1) begin
            tests_run++;
            if (fetch_data !== 16'h1000 + 16'(words)) begin
               tests_failed++;
               $display("FAIL stream_order: got %h, want %h", fetch_data, 16'h1000 + 16'(words));
            end
            words++;
            a++;
         end
         clk_edge();
      end
      tests_run++;
      if (words != n_cycles - LAT) begin
         tests_failed++;
         $display("FAIL stream_throughput: got %0d words, want %0d", words, n_cycles - LAT);
      end
   endtask

   // Hold at address 5 without taking: issue stops once DEPTH words are queued.
   task automatic test_stall();
      int issues;
      issues = 0;
      fetch_addr = 16'd5;
      fetch_take = 1'b0;
      for (int c = 0; c < 10; c++) begin
         eval();
         if (rom_en === 1'b1) issues++;
         if (c >= LAT) begin
            tests_run++;
            if (fetch_valid !== 1'b1 || fetch_data !== 16'h1005) begin
               tests_failed++;
               $display("FAIL stall_hold cycle %0d: got valid=%b data=%h, want 1 1005", c, fetch_valid, fetch_data);
            end
         end
         clk_edge();
      end
      tests_run++;
      if (issues != DEPTH) begin
         tests_failed++;
         $display("FAIL stall_issue_count: got %0d reads, want %0d", issues, DEPTH);
      end
      fetch_take = 1'b1;
      for (int k = 0; k < 5; k++) begin
         fetch_addr = 16'(5 + k);
         eval();
         tests_run++;
         if (fetch_valid !== 1'b1 || fetch_data !== 16'(16'h1005 + k)) begin
            tests_failed++;
            $display("FAIL stall_resume word %0d: got valid=%b data=%h, want 1 %h",
                     k, fetch_valid, fetch_data, 16'(16'h1005 + k));
         end
         clk_edge();
      end
   endtask

   // Redirect to 0x40 while a response for the 0x30 stream is arriving.
   task automatic test_redirect_drop();
      logic [ADDR_W-1:0] a;
      int words;
      a = 16'h0030;
      fetch_take = 1'b1;
      for (int c = 0; c < 8; c++) begin
         fetch_addr = a;
         eval();
         if (fetch_valid === 1'b1) a++;
         clk_edge();
      end
      tests_run++;
      if (rom_en_s !== 1'b1) begin
         tests_failed++;
         $display("FAIL redirect_precondition: got rom_en=%b before redirect, want 1", rom_en_s);
      end
      fetch_addr = 16'h0040;
      eval();
      tests_run++;
      if (fetch_valid !== 1'b0 || rom_en !== 1'b1 || rom_addr !== 16'h0040) begin
         tests_failed++;
         $display("FAIL redirect_cycle: got valid=%b en=%b addr=%h, want 0 1 0040", fetch_valid, rom_en, rom_addr);
      end
      clk_edge();
      a = 16'h0040;
      words = 0;
      for (int c = 1; c <= 8; c++) begin
         fetch_addr = a;
         eval();
         tests_run++;
         if (fetch_valid !== (c >= LAT)) begin
            tests_failed++;
            $display("FAIL redirect_latency cycle %0d: got %b, want %b", c, fetch_valid, (c >= LAT));
         end
         if (fetch_valid === 1'b1) begin
            tests_run++;
            if (fetch_data !== 16'h1040 + 16'(words)) begin
               tests_failed++;
               $display("FAIL redirect_order: got %h, want %h", fetch_data, 16'h1040 + 16'(words));
            end
            words++;
            a++;
         end
         clk_edge();
      end
   endtask

   // Stream across the top of the address space.
   task automatic test_wrap();
      logic [ADDR_W-1:0] a;
      logic [15:0] exp_seq [4];
      int idx;
      logic saw_zero;
      exp_seq[0] = 16'hFFFE;
      exp_seq[1] = 16'hFFFF;
      exp_seq[2] = 16'h0000;
      exp_seq[3] = 16'h0001;
      a = 16'hFFFE;
      idx = 0;
      saw_zero = 1'b0;
      fetch_take = 1'b1;
      for (int c = 0; c < 8; c++) begin
         fetch_addr = a;
         eval();
         if (rom_en === 1'b1 && rom_addr === 16'h0000) saw_zero = 1'b1;
         if (fetch_valid === 1'b1) begin
            if (idx < 4) begin
               tests_run++;
               if (fetch_data !== 16'h1000 + exp_seq[idx]) begin
                  tests_failed++;
                  $display("FAIL wrap_order %0d: got %h, want %h", idx, fetch_data, 16'h1000 + exp_seq[idx]);
               end
            end
            idx++;
            a++;
         end
         clk_edge();
      end
      tests_run++;
      if (saw_zero !== 1'b1 || idx < 4) begin
         tests_failed++;
         $display("FAIL wrap_rom_addr: got saw_zero=%b words=%0d, want 1 >=4", saw_zero, idx);
      end
   endtask

   // Reset while three words are queued and one read is in flight.
   task automatic test_mid_reset();
      fetch_addr = 16'h0100;
      fetch_take = 1'b0;
      for (int c = 0; c < 4; c++) begin
         eval();
         clk_edge();
      end
      eval();
      tests_run++;
      if (fetch_valid !== 1'b1 || rom_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_precondition: got valid=%b en=%b, want 1 0", fetch_valid, rom_en);
      end
      RST = 1'b1;
      clk_edge();
      fetch_addr = '0;
      eval();
      check_reset_outputs("midreset_values");
      clk_edge();
      test_stream(12);
   endtask

   // Sequential flow with random take: once the first word is present there is never a bubble.
   task automatic test_random_flow();
      logic [ADDR_W-1:0] a;
      int taken;
      a = 16'($urandom_range(16'h2000, 16'hEFFF));
      taken = 0;
      for (int c = 0; c < 200; c++) begin
         fetch_addr = a;
         fetch_take = 1'($urandom_range(0, 1));
         eval();
         if (c >= LAT) begin
            tests_run++;
            if (fetch_valid !== 1'b1) begin
               tests_failed++;
               $display("FAIL random_flow_bubble cycle %0d: got valid=%b, want 1", c, fetch_valid);
            end
         end
         if (fetch_valid === 1'b1 && fetch_take === 1'b1) begin
            a++;
            taken++;
         end
         clk_edge();
      end
      tests_run++;
      if (taken == 0) begin
         tests_failed++;
         $display("FAIL random_flow_progress: got 0 words taken, want >0");
      end
   endtask

   // Redirect every other cycle between a few targets; the scoreboard catches stale words.
   task automatic test_pingpong();
      logic [ADDR_W-1:0] h;
      logic [ADDR_W-1:0] target;
      h = fetch_addr;
      for (int c = 0; c < 60; c++) begin
         if (c % 2 == 0) begin
            case ($urandom_range(0, 2))
               0:       target = 16'h0010;
               1:       target = 16'h0020;
               default: target = 16'($urandom);
            endcase
            fetch_addr = target;
         end else begin
            fetch_addr = h;
         end
         fetch_take = 1'($urandom_range(0, 1));
         eval();
         if (fetch_addr != h) begin
            tests_run++;
            if (fetch_valid !== 1'b0 || rom_addr !== fetch_addr) begin
               tests_failed++;
               $display("FAIL pingpong_redirect cycle %0d: got valid=%b rom_addr=%h, want 0 %h",
                        c, fetch_valid, rom_addr, fetch_addr);
            end
         end
         h = fetch_addr + ADDR_W'(fetch_valid & fetch_take);
         clk_edge();
      end
   endtask

   initial begin
      test_reset();
      test_stream(20);
      test_stall();
      test_redirect_drop();
      test_wrap();
      test_mid_reset();
      test_random_flow();
      test_pingpong();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
